// File: rtl/ahb_lite_arb2_pkg.sv
// Shared AHB-Lite codes and arbiter state encoding for the
// two-master AHB-Lite arbiter.
package ahb_lite_arb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // Also used as the owner encoding: ST_PARK means "no owner".
    typedef enum logic [1:0] {
        ST_PARK = 2'b00,
        ST_M0   = 2'b01,
        ST_M1   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ahb_rr_arb2.sv
// Grant FSM for two AHB-Lite masters: round-robin from park,
// forced handover once the owner has used its phase budget.
module ahb_rr_arb2
    import ahb_lite_arb2_pkg::*;
#(
    parameter int MAX_XFER = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ready,
    input  logic [1:0] i_req,
    input  logic [1:0] i_act,
    output arb_state_e o_state
);

    localparam int CW = $clog2(MAX_XFER + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_XFER);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic          r_last_m1;
    logic          w_last_m1_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_upd;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_inc;

    // xfer_cnt counts address phases the owner issues while granted;
    // it includes the phase being counted on this edge, so the bus
    // sees exactly MAX_XFER owner phases before a forced handover.
    always_comb begin
        w_inc = ((r_state == ST_M0) && i_act[0]) ||
                ((r_state == ST_M1) && i_act[1]);
        w_cnt_upd = r_cnt;
        if (w_inc && (r_cnt != CMAX))
            w_cnt_upd = r_cnt + CW'(1);

        w_state_nxt = r_state;
        unique case (r_state)
            ST_PARK: begin
                if (i_req == 2'b11)
                    w_state_nxt = r_last_m1 ? ST_M0 : ST_M1;
                else if (i_req[0])
                    w_state_nxt = ST_M0;
                else if (i_req[1])
                    w_state_nxt = ST_M1;
            end
            ST_M0: begin
                if (!i_req[0])
                    w_state_nxt = i_req[1] ? ST_M1 : ST_PARK;
                else if (i_req[1] && (w_cnt_upd == CMAX))
                    w_state_nxt = ST_M1;
            end
            ST_M1: begin
                if (!i_req[1])
                    w_state_nxt = i_req[0] ? ST_M0 : ST_PARK;
                else if (i_req[0] && (w_cnt_upd == CMAX))
                    w_state_nxt = ST_M0;
            end
            default: w_state_nxt = ST_PARK;
        endcase

        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : w_cnt_upd;

        w_last_m1_nxt = r_last_m1;
        if (w_state_nxt == ST_M0)
            w_last_m1_nxt = 1'b0;
        else if (w_state_nxt == ST_M1)
            w_last_m1_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_PARK;
            r_last_m1 <= 1'b1;
            r_cnt     <= '0;
        end else if (i_ready) begin
            r_state   <= w_state_nxt;
            r_last_m1 <= w_last_m1_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter: registered grants, address/data
// owner pipeline and slave-side muxing.
module ahb_lite_arb2
    import ahb_lite_arb2_pkg::*;
#(
    parameter int AW       = 12,
    parameter int MAX_XFER = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          M0_HBUSREQ,
    input  logic          M1_HBUSREQ,
    output logic          M0_HGRANT,
    output logic          M1_HGRANT,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic [2:0]    M0_HSIZE,
    input  logic          M0_HWRITE,
    input  logic [31:0]   M0_HWDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic [2:0]    M1_HSIZE,
    input  logic          M1_HWRITE,
    input  logic [31:0]   M1_HWDATA,
    output logic          M0_HREADY,
    output logic [31:0]   M0_HRDATA,
    output logic          M0_HRESP,
    output logic          M1_HREADY,
    output logic [31:0]   M1_HRDATA,
    output logic          M1_HRESP,
    output logic          HSEL,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    output logic          HREADY,
    input  logic          HREADYOUT,
    input  logic [31:0]   HRDATA,
    input  logic          HRESP
);

    arb_state_e w_state;
    arb_state_e r_addr_owner;
    arb_state_e r_data_owner;

    ahb_rr_arb2 #(
        .MAX_XFER (MAX_XFER)
    ) u_arb (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_ready (HREADYOUT),
        .i_req   ({M1_HBUSREQ, M0_HBUSREQ}),
        .i_act   ({M1_HTRANS[1], M0_HTRANS[1]}),
        .o_state (w_state)
    );

    // Owners only move on accepted edges so a stalled data phase
    // keeps its master regardless of grant activity.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr_owner <= ST_PARK;
            r_data_owner <= ST_PARK;
        end else if (HREADYOUT) begin
            r_addr_owner <= w_state;
            r_data_owner <= r_addr_owner;
        end
    end

    assign M0_HGRANT = (w_state == ST_M0);
    assign M1_HGRANT = (w_state == ST_M1);

    always_comb begin
        HADDR  = '0;
        HTRANS = HTRANS_IDLE;
        HSIZE  = '0;
        HWRITE = 1'b0;
        unique case (r_addr_owner)
            ST_M0: begin
                HADDR  = M0_HADDR;
                HTRANS = M0_HTRANS;
                HSIZE  = M0_HSIZE;
                HWRITE = M0_HWRITE;
            end
            ST_M1: begin
                HADDR  = M1_HADDR;
                HTRANS = M1_HTRANS;
                HSIZE  = M1_HSIZE;
                HWRITE = M1_HWRITE;
            end
            default: ;
        endcase
    end

    always_comb begin
        HWDATA = '0;
        unique case (r_data_owner)
            ST_M0:   HWDATA = M0_HWDATA;
            ST_M1:   HWDATA = M1_HWDATA;
            default: ;
        endcase
    end

    assign HSEL      = (r_addr_owner != ST_PARK);
    assign HREADY    = HREADYOUT;
    assign M0_HREADY = HREADYOUT;
    assign M1_HREADY = HREADYOUT;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HRESP  = HRESP;
    assign M1_HRESP  = HRESP;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Self-checking bench for ahb_lite_arb2: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_ahb_lite_arb2;

    localparam int AW   = 12;
    localparam int MAXX = 4;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] SZ_W   = 3'b010;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          M0_HBUSREQ, M1_HBUSREQ;
    logic          M0_HGRANT, M1_HGRANT;
    logic [AW-1:0] M0_HADDR, M1_HADDR;
    logic [1:0]    M0_HTRANS, M1_HTRANS;
    logic [2:0]    M0_HSIZE, M1_HSIZE;
    logic          M0_HWRITE, M1_HWRITE;
    logic [31:0]   M0_HWDATA, M1_HWDATA;
    logic          M0_HREADY, M1_HREADY;
    logic [31:0]   M0_HRDATA, M1_HRDATA;
    logic          M0_HRESP, M1_HRESP;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 = nobody, 1 = M0, 2 = M1
    int m_gnt, m_last, m_cnt, m_aown, m_down;

    ahb_lite_arb2 #(.AW(AW), .MAX_XFER(MAXX)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
        .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
        .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
        .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA),
        .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M0_HRESP(M0_HRESP),
        .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .M1_HRESP(M1_HRESP),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic model_reset();
        m_gnt = 0; m_last = 2; m_cnt = 0; m_aown = 0; m_down = 0;
    endtask

    task automatic model_edge();
        bit rq[3];
        bit ac[3];
        int cnt, nxt, oth;
        if (HRESETn !== 1'b1) begin
            model_reset();
            return;
        end
        if (HREADYOUT !== 1'b1) return;
        rq = '{1'b0, M0_HBUSREQ, M1_HBUSREQ};
        ac = '{1'b0, M0_HTRANS[1], M1_HTRANS[1]};
        cnt = m_cnt + int'(ac[m_gnt]);
        if (cnt > MAXX) cnt = MAXX;
        nxt = m_gnt;
        if (m_gnt == 0) begin
            if (rq[1] && rq[2]) nxt = 3 - m_last;
            else if (rq[1]) nxt = 1;
            else if (rq[2]) nxt = 2;
        end else begin
            oth = 3 - m_gnt;
            if (!rq[m_gnt]) nxt = rq[oth] ? oth : 0;
            else if (rq[oth] && cnt == MAXX) nxt = oth;
        end
        m_down = m_aown;
        m_aown = m_gnt;
        if (nxt != m_gnt) begin
            m_cnt = 0;
            if (nxt != 0) m_last = nxt;
        end else begin
            m_cnt = cnt;
        end
        m_gnt = nxt;
    endtask

    function automatic logic [18:0] exp_abus();
        case (m_aown)
            1: return {1'b1, M0_HTRANS, M0_HADDR, M0_HSIZE, M0_HWRITE};
            2: return {1'b1, M1_HTRANS, M1_HADDR, M1_HSIZE, M1_HWRITE};
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata();
        case (m_down)
            1: return M0_HWDATA;
            2: return M1_HWDATA;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] exp_gnt();
        case (m_gnt)
            1: return 2'b01;
            2: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic idle_masters();
        M0_HBUSREQ = 0; M1_HBUSREQ = 0;
        M0_HADDR = '0; M0_HTRANS = T_IDLE; M0_HSIZE = '0;
        M0_HWRITE = 0; M0_HWDATA = '0;
        M1_HADDR = '0; M1_HTRANS = T_IDLE; M1_HSIZE = '0;
        M1_HWRITE = 0; M1_HWDATA = '0;
        HREADYOUT = 1; HRDATA = '0; HRESP = 0;
    endtask

    task automatic do_reset();
        HRESETn = 0;
        model_reset();
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1;
    endtask

    task automatic test_reset();
        idle_masters();
        M0_HTRANS = T_NSEQ; M1_HTRANS = T_SEQ;
        M0_HWDATA = 32'hFFFF_FFFF; M1_HWDATA = 32'hEEEE_EEEE;
        HRESETn = 0;
        model_reset();
        #2;
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_gnt: got %b want 00", {M1_HGRANT, M0_HGRANT});
        end
        n_tests++;
        if ({HSEL, HTRANS} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_bus: got %b want 000", {HSEL, HTRANS});
        end
        n_tests++;
        if (HWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wdata: got %h want 0", HWDATA);
        end
        @(posedge HCLK);
        #1 HRESETn = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({M1_HGRANT, M0_HGRANT, HSEL, HTRANS} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_cyc%0d: got gnt/hsel/htrans %b want 00000",
                         i, {M1_HGRANT, M0_HGRANT, HSEL, HTRANS});
            end
        end
    endtask

    task automatic test_tie_write();
        idle_masters();
        do_reset();
        M0_HBUSREQ = 1; M1_HBUSREQ = 1;
        tick();
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_gnt: got %b want 01", {M1_HGRANT, M0_HGRANT});
        end
        M1_HBUSREQ = 0;
        M0_HTRANS = T_NSEQ; M0_HADDR = 12'h010; M0_HWRITE = 1;
        M0_HSIZE = SZ_W; M0_HWDATA = 32'hFFFF_FFFF;
        M1_HTRANS = T_NSEQ; M1_HADDR = 12'h7F0;
        tick();
        n_tests++;
        if ({HSEL, HTRANS, HADDR, HSIZE, HWRITE} !==
            {1'b1, T_NSEQ, 12'h010, SZ_W, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_addr: got sel %b tr %b a %h sz %b w %b want 1 10 010 010 1",
                     HSEL, HTRANS, HADDR, HSIZE, HWRITE);
        end
        n_tests++;
        if (HWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL tie_nodata: got %h want 0", HWDATA);
        end
        tick();
        M0_HTRANS = T_IDLE; M0_HADDR = 12'h3FC;
        M0_HWDATA = 32'hA5A5_A5A5; M1_HWDATA = 32'h1234_5678;
        #1;
        n_tests++;
        if (HWDATA !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL tie_wdata: got %h want a5a5a5a5", HWDATA);
        end
        n_tests++;
        if (HTRANS !== T_IDLE) begin
            n_fail++;
            $display("FAIL tie_idle: got %b want 00", HTRANS);
        end
    endtask

    task automatic test_handover();
        logic [AW-1:0] seen[$];
        logic [AW-1:0] rec_a;
        logic          rec_v;
        int            k;
        bit            got_m1;
        idle_masters();
        do_reset();
        M0_HBUSREQ = 1;
        tick();
        M1_HBUSREQ = 1; M1_HTRANS = T_NSEQ; M1_HADDR = 12'h800;
        k = 0;
        got_m1 = 0;
        for (int c = 0; c < 20 && !got_m1; c++) begin
            M0_HTRANS = (k < 6) ? T_NSEQ : T_IDLE;
            M0_HADDR  = 12'h100 + 12'(4 * k);
            #1;
            rec_v = HSEL && HTRANS[1];
            rec_a = HADDR;
            tick();
            if (rec_v) begin
                if (rec_a == 12'h800) got_m1 = 1;
                else begin
                    seen.push_back(rec_a);
                    if (rec_a == M0_HADDR) k++;
                end
            end
        end
        n_tests++;
        if (!got_m1) begin
            n_fail++;
            $display("FAIL ho_timeout: got no M1 phase want one within 20 cycles");
        end
        n_tests++;
        if (seen.size() != MAXX || k != MAXX) begin
            n_fail++;
            $display("FAIL ho_count: got %0d phases (k=%0d) want %0d",
                     seen.size(), k, MAXX);
        end
        foreach (seen[i]) begin
            n_tests++;
            if (seen[i] !== 12'h100 + 12'(4 * i)) begin
                n_fail++;
                $display("FAIL ho_addr%0d: got %h want %h",
                         i, seen[i], 12'h100 + 12'(4 * i));
            end
        end
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b10) begin
            n_fail++;
            $display("FAIL ho_gnt: got %b want 10", {M1_HGRANT, M0_HGRANT});
        end
    endtask

    task automatic test_wait_states();
        idle_masters();
        do_reset();
        M1_HBUSREQ = 1;
        tick();
        M1_HTRANS = T_NSEQ; M1_HADDR = 12'h020; M1_HWRITE = 1; M1_HSIZE = SZ_W;
        tick();
        tick();
        M1_HTRANS = T_IDLE; M1_HWDATA = 32'h5A5A_0001;
        M0_HWDATA = 32'hBAD0_BAD0;
        M1_HBUSREQ = 0; M0_HBUSREQ = 1; HREADYOUT = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (HWDATA !== 32'h5A5A_0001 || {M1_HGRANT, M0_HGRANT} !== 2'b10) begin
                n_fail++;
                $display("FAIL stall%0d: got wdata %h gnt %b want 5a5a0001 10",
                         i, HWDATA, {M1_HGRANT, M0_HGRANT});
            end
        end
        HREADYOUT = 1;
        #1;
        n_tests++;
        if (HWDATA !== 32'h5A5A_0001) begin
            n_fail++;
            $display("FAIL stall_end: got %h want 5a5a0001", HWDATA);
        end
        tick();
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_gnt: got %b want 01", {M1_HGRANT, M0_HGRANT});
        end
    endtask

    task automatic test_park_rr();
        idle_masters();
        do_reset();
        M1_HBUSREQ = 1; M1_HTRANS = T_NSEQ; M1_HADDR = 12'h0A0;
        tick();
        M1_HBUSREQ = 0;
        tick();
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b00) begin
            n_fail++;
            $display("FAIL park_gnt: got %b want 00", {M1_HGRANT, M0_HGRANT});
        end
        tick();
        n_tests++;
        if ({HSEL, HTRANS} !== 3'b000) begin
            n_fail++;
            $display("FAIL park_bus: got %b want 000", {HSEL, HTRANS});
        end
        M0_HBUSREQ = 1; M1_HBUSREQ = 1;
        tick();
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_m0: got %b want 01", {M1_HGRANT, M0_HGRANT});
        end
        M0_HBUSREQ = 0; M1_HBUSREQ = 0;
        tick();
        M0_HBUSREQ = 1; M1_HBUSREQ = 1;
        tick();
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT} !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_m1: got %b want 10", {M1_HGRANT, M0_HGRANT});
        end
    endtask

    task automatic test_reset_mid();
        idle_masters();
        do_reset();
        M0_HBUSREQ = 1;
        tick();
        M0_HTRANS = T_NSEQ; M0_HADDR = 12'h040; M0_HWRITE = 1;
        M0_HWDATA = 32'hDEAD_BEEF;
        tick();
        tick();
        tick();
        n_tests++;
        if ({HSEL, M0_HGRANT, HWDATA} !== {2'b11, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL mid_pre: got sel %b gnt %b wdata %h want 1 1 deadbeef",
                     HSEL, M0_HGRANT, HWDATA);
        end
        #2 HRESETn = 0;
        model_reset();
        #1;
        n_tests++;
        if ({M1_HGRANT, M0_HGRANT, HSEL, HTRANS} !== 5'b0 || HWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst: got gnt/sel/tr %b wdata %h want 00000 0",
                     {M1_HGRANT, M0_HGRANT, HSEL, HTRANS}, HWDATA);
        end
        @(posedge HCLK);
        #1 HRESETn = 1;
    endtask

    task automatic test_random();
        idle_masters();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            M0_HBUSREQ = ($urandom_range(0, 3) != 0);
            M1_HBUSREQ = ($urandom_range(0, 3) != 0);
            M0_HTRANS  = 2'($urandom_range(0, 3));
            M1_HTRANS  = 2'($urandom_range(0, 3));
            M0_HADDR   = 12'($urandom);
            M1_HADDR   = 12'($urandom);
            M0_HSIZE   = 3'($urandom);
            M1_HSIZE   = 3'($urandom);
            M0_HWRITE  = 1'($urandom);
            M1_HWRITE  = 1'($urandom);
            M0_HWDATA  = $urandom;
            M1_HWDATA  = $urandom;
            HREADYOUT  = ($urandom_range(0, 3) != 0);
            HRDATA     = $urandom;
            HRESP      = 1'($urandom);
            #1;
            n_tests++;
            if ({HSEL, HTRANS, HADDR, HSIZE, HWRITE} !== exp_abus()) begin
                n_fail++;
                $display("FAIL rnd_abus%0d: got %h want %h", i,
                         {HSEL, HTRANS, HADDR, HSIZE, HWRITE}, exp_abus());
            end
            n_tests++;
            if (HWDATA !== exp_wdata()) begin
                n_fail++;
                $display("FAIL rnd_wdata%0d: got %h want %h", i, HWDATA, exp_wdata());
            end
            n_tests++;
            if ({M1_HGRANT, M0_HGRANT} !== exp_gnt()) begin
                n_fail++;
                $display("FAIL rnd_gnt%0d: got %b want %b", i,
                         {M1_HGRANT, M0_HGRANT}, exp_gnt());
            end
            n_tests++;
            if ({HREADY, M0_HREADY, M1_HREADY, M0_HRDATA, M1_HRDATA, M0_HRESP, M1_HRESP}
                !== {{3{HREADYOUT}}, HRDATA, HRDATA, HRESP, HRESP}) begin
                n_fail++;
                $display("FAIL rnd_bcast%0d: got rdy %b%b%b rd %h/%h rsp %b%b want %b %h %b",
                         i, HREADY, M0_HREADY, M1_HREADY, M0_HRDATA, M1_HRDATA,
                         M0_HRESP, M1_HRESP, HREADYOUT, HRDATA, HRESP);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_tie_write();
        test_handover();
        test_wait_states();
        test_park_rr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
